stopwatch_button_conditioner: RTL and testbench
===============================================

// Module: stopwatch_button_conditioner
// PURPOSE
//  Input-side front end for the stopwatch: turns raw, bouncing, asynchronous push-button inputs into
//  clean active-low levels plus single-cycle event pulses. Sits between the board keys and the
//  stopwatch control logic, which consumes the active-low start_stop/hold/reset_n style levels.
//  Runs in the 50 MHz domain, ahead of the 100 Hz divider. Adds long-press detection per key.
// PARAMETERS
//  NUM_BTNS       3           number of independent button channels
//  CLK_FREQ_HZ    50_000_000  input clock frequency
//  DEBOUNCE_MS    10          stable time required to accept a level change (>=1)
//  LONG_PRESS_MS  1000        debounced hold time that fires long_press (> DEBOUNCE_MS)
//  Derived: DB_CYC = CLK_FREQ_HZ/1000*DEBOUNCE_MS (must be >=2); LP_CYC = CLK_FREQ_HZ/1000*LONG_PRESS_MS
// PORTS
//  CLK_50MHz       in   1         system clock, single clock domain
//  reset_n         in   1         synchronous, active-low reset
//  raw_btn_n       in   NUM_BTNS  raw key inputs, active low, asynchronous, bouncing
//  btn_level_n     out  NUM_BTNS  debounced level, active low (0 = pressed)
//  btn_press       out  NUM_BTNS  1-cycle pulse on accepted press
//  btn_release     out  NUM_BTNS  1-cycle pulse on accepted release
//  btn_long_press  out  NUM_BTNS  1-cycle pulse once per press after LP_CYC cycles held
// BEHAVIOUR
//  - Reset (reset_n=0 at a clock edge): btn_level_n=all 1, all pulse outputs 0, synchronizer flops=1,
//    every channel -> IDLE, counters 0. Reset mid-debounce/mid-press discards all progress, no pulses.
//  - Per channel: 2-flop synchronizer (sync0->sync1); FSM and counters use sync1 only.
//  - FSM states: IDLE (released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
//    IDLE: sync1=0 -> PRESS_WAIT, db_cnt=1.
//    PRESS_WAIT: sync1=1 -> IDLE, db_cnt=0 (bounce rejected, no pulse);
//      sync1=0 & db_cnt==DB_CYC-1 -> PRESSED; else db_cnt++.
//    PRESSED: sync1=1 -> RELEASE_WAIT, db_cnt=1.
//    RELEASE_WAIT: sync1=0 -> PRESSED (no new press pulse); sync1=1 & db_cnt==DB_CYC-1 -> IDLE; else db_cnt++.
//  - Latency: raw stable low from edge 1 -> btn_level_n falls registered at edge DB_CYC+2;
//    release symmetric. btn_press asserted exactly the cycle btn_level_n first reads 0; btn_release the
//    cycle it first reads 1. Pulses never longer than 1 cycle.
//  - Long press: hold_cnt clears on entering PRESSED from PRESS_WAIT, increments each cycle in PRESSED and
//    RELEASE_WAIT, saturates at LP_CYC-1; btn_long_press pulses once on the increment to LP_CYC-1.
//    No auto-repeat. Cleared on entering IDLE.
//  - Widths: db_cnt = $clog2(DB_CYC) bits, hold_cnt = $clog2(LP_CYC) bits; no wrap (saturate/clear only).
//  - Channels fully independent; simultaneous presses on several keys each produce their own pulses
//    in the same cycle if timing coincides. No priority or lockout between keys.
//  - Key held during reset release: synchronizers start at 1, so a full debounce runs and btn_press fires
//    DB_CYC+2 edges after reset deasserts (intentional; not suppressed).
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3),
//    ms-to-cycle conversion constant function.
//  - One sub-module: debounce_channel (synchronizer + FSM + both counters + pulse regs), generated
//    NUM_BTNS times; top only slices the vectors.
// TESTING  (bench overrides CLK_FREQ_HZ=10_000, DEBOUNCE_MS=2, LONG_PRESS_MS=10 -> DB_CYC=20, LP_CYC=100)
//  1 Clean press: raw_btn_n[0] 1->0 held 200 cyc -> level_n[0]=0 at edge 22, btn_press[0] 1 cyc at edge 22,
//    btn_long_press[0] once at 100 cycles after that edge; other channels idle.
//  2 Bounce reject: raw low 15 cyc, high 5, low 15, high -> no press pulse, level_n stays 1.
//  3 Release bounce: pressed key, raw high 10 cyc then low again -> no release/press pulse, no second
//    long_press; final stable high 20+ cyc -> one btn_release.
//  4 Reset mid-press: reset_n=0 for 1 edge at cycle 10 of PRESS_WAIT -> all outputs reset values;
//    raw still low -> press pulse DB_CYC+2 edges after reset deasserts.
//  5 Simultaneous: raw_btn_n=3'b000 on the same edge -> btn_press=3'b111 in one cycle at edge 22.
//  6 Short tap: press held 50 cyc (< LP_CYC) then release -> press and release pulses, no long_press.

Source files
------------

// File: rtl/stopwatch_button_conditioner_pkg.sv
// rtl/stopwatch_button_conditioner_pkg.sv - shared types and helpers for the button conditioner
//
// Purpose: per-channel debounce FSM state encoding and the ms-to-cycles
//          conversion used to size the debounce and long-press counters.
// Ports:   none (package).

package stopwatch_button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Integer clock cycles spanned by 'ms' milliseconds at 'clk_hz'.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/stopwatch_button_conditioner_debounce_channel.sv
// rtl/stopwatch_button_conditioner_debounce_channel.sv - one key: synchronizer, debounce FSM, long-press timer
//
// Purpose: conditions a single raw active-low key into a debounced level and
//          single-cycle press / release / long-press pulses.
// Ports:
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   raw_n_i       raw asynchronous bouncing key, active low
//   level_n_o     debounced level, active low
//   press_o       1-cycle pulse when a press is accepted
//   release_o     1-cycle pulse when a release is accepted
//   long_press_o  1-cycle pulse once per press, LP_CYC cycles after press_o

module debounce_channel
  import stopwatch_button_conditioner_pkg::*;
#(
  parameter int DB_CYC = 20,
  parameter int LP_CYC = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_n_i,
  output logic level_n_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int HOLD_W = (LP_CYC > 1) ? $clog2(LP_CYC) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYC - 1);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LP_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LP_CYC - 2);

  logic sync0_q, sync1_q;
  btn_state_e state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic level_n_q, level_n_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic lp_hit_q, lp_hit_d;
  logic long_press_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync0_q      <= 1'b1;
      sync1_q      <= 1'b1;
      state_q      <= ST_IDLE;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      level_n_q    <= 1'b1;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      lp_hit_q     <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      sync0_q      <= raw_n_i;
      sync1_q      <= sync0_q;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      level_n_q    <= level_n_d;
      press_q      <= press_d;
      release_q    <= release_d;
      lp_hit_q     <= lp_hit_d;
      // One extra stage so the long-press pulse lands exactly LP_CYC
      // cycles after the press pulse (hold_cnt reaches its top one
      // cycle earlier because it starts from 0 on the press edge).
      long_press_q <= lp_hit_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_n_d  = level_n_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    lp_hit_d   = 1'b0;

    // Hold timer runs while the key is debounced-pressed, including the
    // release-qualification window; it saturates, so no auto-repeat.
    if ((state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) && hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      lp_hit_d   = (hold_cnt_q == HOLD_PRE);
    end

    unique case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (!sync1_q) begin
          state_d  = ST_PRESS_WAIT;
          db_cnt_d = DB_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (sync1_q) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
          state_d    = ST_PRESSED;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          level_n_d  = 1'b0;
          press_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (sync1_q) begin
          state_d  = ST_RELEASE_WAIT;
          db_cnt_d = DB_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync1_q) begin
          // Release bounce: return to PRESSED without a new press pulse and
          // keep the hold timer so long-press cannot fire twice.
          state_d  = ST_PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
          state_d    = ST_IDLE;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          lp_hit_d   = 1'b0;
          level_n_d  = 1'b1;
          release_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  assign level_n_o    = level_n_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_press_q;

endmodule

// File: rtl/stopwatch_button_conditioner.sv
// rtl/stopwatch_button_conditioner.sv - stopwatch push-button front end
//
// Purpose: turns NUM_BTNS raw bouncing active-low keys into debounced
//          active-low levels plus press / release / long-press pulses.
//          Channels are independent; the top only slices vectors.
// Ports:
//   CLK_50MHz       system clock
//   reset_n         synchronous active-low reset
//   raw_btn_n       raw keys, active low, asynchronous
//   btn_level_n     debounced levels, active low
//   btn_press       1-cycle press pulses
//   btn_release     1-cycle release pulses
//   btn_long_press  1-cycle long-press pulses

module stopwatch_button_conditioner
  import stopwatch_button_conditioner_pkg::*;
#(
  parameter int NUM_BTNS      = 3,
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic                CLK_50MHz,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] raw_btn_n,
  output logic [NUM_BTNS-1:0] btn_level_n,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_long_press
);

  localparam int DB_CYC = int'(ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS));
  localparam int LP_CYC = int'(ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS));

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    debounce_channel #(
      .DB_CYC(DB_CYC),
      .LP_CYC(LP_CYC)
    ) u_chan (
      .clk_i        (CLK_50MHz),
      .rst_ni       (reset_n),
      .raw_n_i      (raw_btn_n[g]),
      .level_n_o    (btn_level_n[g]),
      .press_o      (btn_press[g]),
      .release_o    (btn_release[g]),
      .long_press_o (btn_long_press[g])
    );
  end

endmodule

// File: tb/tb_stopwatch_button_conditioner.sv
// tb/tb_stopwatch_button_conditioner.sv - directed self-checking bench for the button conditioner

module tb_stopwatch_button_conditioner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] raw_btn_n;
  logic [2:0] btn_level_n, btn_press, btn_release, btn_long_press;

  int errors = 0;
  int checks = 0;

  // Per-channel event recorder (edges numbered from the last clear_rec).
  int edge_n;
  int pc[3], pe[3], rc[3], re[3], lc[3], le[3], lf[3];
  logic [2:0] first_press_vec;
  int first_press_edge;

  stopwatch_button_conditioner #(
    .NUM_BTNS(3),
    .CLK_FREQ_HZ(10_000),
    .DEBOUNCE_MS(2),
    .LONG_PRESS_MS(10)
  ) dut (
    .CLK_50MHz     (clk),
    .reset_n       (reset_n),
    .raw_btn_n     (raw_btn_n),
    .btn_level_n   (btn_level_n),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .btn_long_press(btn_long_press)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    edge_n = 0;
    first_press_vec = 3'b000;
    first_press_edge = -1;
    for (int i = 0; i < 3; i++) begin
      pc[i] = 0; pe[i] = -1; rc[i] = 0; re[i] = -1;
      lc[i] = 0; le[i] = -1; lf[i] = -1;
    end
  endtask

  task automatic tick_rec(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      edge_n++;
      if (btn_press !== 3'b000 && first_press_edge < 0) begin
        first_press_vec  = btn_press;
        first_press_edge = edge_n;
      end
      for (int i = 0; i < 3; i++) begin
        if (btn_press[i] === 1'b1) begin pc[i]++; if (pe[i] < 0) pe[i] = edge_n; end
        if (btn_release[i] === 1'b1) begin rc[i]++; if (re[i] < 0) re[i] = edge_n; end
        if (btn_long_press[i] === 1'b1) begin lc[i]++; if (le[i] < 0) le[i] = edge_n; end
        if (btn_level_n[i] === 1'b0 && lf[i] < 0) lf[i] = edge_n;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    raw_btn_n = 3'b111;
    repeat (3) tick();
    checks++;
    if (btn_level_n !== 3'b111) begin errors++; $display("FAIL reset_level got=%b exp=111", btn_level_n); end
    checks++;
    if ({btn_press, btn_release, btn_long_press} !== 9'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0", {btn_press, btn_release, btn_long_press});
    end
    reset_n = 1'b1;
    clear_rec();
    tick_rec(10);
    checks++;
    if (btn_level_n !== 3'b111 || pc[0] + pc[1] + pc[2] != 0) begin
      errors++; $display("FAIL idle_after_reset level=%b presses=%0d exp level=111 presses=0", btn_level_n, pc[0] + pc[1] + pc[2]);
    end
  endtask

  task automatic test_clean_press();
    clear_rec();
    raw_btn_n = 3'b110;
    tick_rec(200);
    checks++;
    if (pc[0] != 1 || pe[0] != 22) begin errors++; $display("FAIL clean_press count=%0d edge=%0d exp 1 at 22", pc[0], pe[0]); end
    checks++;
    if (lf[0] != 22) begin errors++; $display("FAIL clean_level_fall edge=%0d exp=22", lf[0]); end
    checks++;
    if (lc[0] != 1 || le[0] != 122) begin errors++; $display("FAIL clean_long count=%0d edge=%0d exp 1 at 122", lc[0], le[0]); end
    checks++;
    if (pc[1] + pc[2] + lc[1] + lc[2] != 0 || btn_level_n[2:1] !== 2'b11) begin
      errors++; $display("FAIL clean_other_chan events=%0d level=%b exp 0 and 11", pc[1] + pc[2] + lc[1] + lc[2], btn_level_n[2:1]);
    end
    clear_rec();
    raw_btn_n = 3'b111;
    tick_rec(40);
    checks++;
    if (rc[0] != 1 || re[0] != 22) begin errors++; $display("FAIL clean_release count=%0d edge=%0d exp 1 at 22", rc[0], re[0]); end
    checks++;
    if (btn_level_n !== 3'b111) begin errors++; $display("FAIL clean_level_back got=%b exp=111", btn_level_n); end
  endtask

  task automatic test_bounce_reject();
    clear_rec();
    raw_btn_n = 3'b110; tick_rec(15);
    raw_btn_n = 3'b111; tick_rec(5);
    raw_btn_n = 3'b110; tick_rec(15);
    raw_btn_n = 3'b111; tick_rec(40);
    checks++;
    if (pc[0] != 0 || rc[0] != 0) begin errors++; $display("FAIL bounce_pulses press=%0d release=%0d exp 0 0", pc[0], rc[0]); end
    checks++;
    if (lf[0] != -1) begin errors++; $display("FAIL bounce_level fell at edge=%0d exp never", lf[0]); end
  endtask

  task automatic test_release_bounce();
    clear_rec();
    raw_btn_n = 3'b110; tick_rec(150);
    raw_btn_n = 3'b111; tick_rec(10);
    raw_btn_n = 3'b110; tick_rec(60);
    checks++;
    if (rc[0] != 0 || pc[0] != 1 || btn_level_n[0] !== 1'b0) begin
      errors++; $display("FAIL relbounce_hold release=%0d press=%0d level=%b exp 0 1 0", rc[0], pc[0], btn_level_n[0]);
    end
    raw_btn_n = 3'b111; tick_rec(40);
    checks++;
    if (lc[0] != 1 || le[0] != 122) begin errors++; $display("FAIL relbounce_long count=%0d edge=%0d exp 1 at 122", lc[0], le[0]); end
    checks++;
    if (rc[0] != 1 || re[0] != 242) begin errors++; $display("FAIL relbounce_release count=%0d edge=%0d exp 1 at 242", rc[0], re[0]); end
  endtask

  task automatic test_reset_mid_press();
    clear_rec();
    raw_btn_n = 3'b110;
    tick_rec(12);
    reset_n = 1'b0;
    tick_rec(1);
    checks++;
    if (btn_level_n !== 3'b111 || {btn_press, btn_release, btn_long_press} !== 9'b0 || pc[0] != 0) begin
      errors++; $display("FAIL midreset_outputs level=%b pulses=%b presses=%0d exp 111 0 0",
                         btn_level_n, {btn_press, btn_release, btn_long_press}, pc[0]);
    end
    reset_n = 1'b1;
    clear_rec();
    tick_rec(40);
    checks++;
    if (pc[0] != 1 || pe[0] != 22) begin errors++; $display("FAIL midreset_press count=%0d edge=%0d exp 1 at 22", pc[0], pe[0]); end
    raw_btn_n = 3'b111;
    tick_rec(40);
  endtask

  task automatic test_simultaneous();
    clear_rec();
    raw_btn_n = 3'b000;
    tick_rec(30);
    checks++;
    if (first_press_vec !== 3'b111 || first_press_edge != 22) begin
      errors++; $display("FAIL simul_press vec=%b edge=%0d exp 111 at 22", first_press_vec, first_press_edge);
    end
    checks++;
    if (pc[0] != 1 || pc[1] != 1 || pc[2] != 1 || btn_level_n !== 3'b000) begin
      errors++; $display("FAIL simul_counts %0d %0d %0d level=%b exp 1 1 1 000", pc[0], pc[1], pc[2], btn_level_n);
    end
    raw_btn_n = 3'b111;
    tick_rec(40);
  endtask

  task automatic test_short_tap();
    clear_rec();
    raw_btn_n = 3'b110; tick_rec(50);
    raw_btn_n = 3'b111; tick_rec(40);
    checks++;
    if (pc[0] != 1 || rc[0] != 1 || re[0] != 72) begin
      errors++; $display("FAIL tap_pulses press=%0d release=%0d rel_edge=%0d exp 1 1 72", pc[0], rc[0], re[0]);
    end
    checks++;
    if (lc[0] != 0) begin errors++; $display("FAIL tap_long count=%0d exp=0", lc[0]); end
  endtask

  initial begin
    clear_rec();
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_release_bounce();
    test_reset_mid_press();
    test_simultaneous();
    test_short_tap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
